// File: rtl/ysyx_25060173_ifu_pkg.sv
// Shared types and constants for the ysyx_25060173 instruction fetch unit.
package ysyx_25060173_ifu_pkg;

  localparam int unsigned IFU_XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_e;

  // A fetch address is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25060173_ifu_if.sv
// Memory-side and core-side handshake bundle of the fetch unit.
// master: the IFU itself; slave: the memory and core around it.
interface ysyx_25060173_ifu_if
  import ysyx_25060173_ifu_pkg::*;
#(
  parameter int unsigned XLEN = IFU_XLEN
) ();

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic            mem_resp_ready;
  logic [XLEN-1:0] mem_resp_data;
  logic            mem_resp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;
  logic [XLEN-1:0] next_pc;

  modport master (
    output mem_req_valid, mem_req_addr, mem_resp_ready,
    output inst_valid, inst, inst_pc, inst_fault,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    input  inst_ready, next_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_resp_ready,
    input  inst_valid, inst, inst_pc, inst_fault,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    output inst_ready, next_pc
  );

endinterface

// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one memory read in flight
// and hands each returned word to the core until it retires.
// Optional macro YSYX_25060173_IFU_MISALIGN_CHECK_EN: a misaligned PC skips the
// memory read and is presented directly as a faulting NOP; without it the low
// address bits are dropped on the request and no fault is raised.
module ysyx_25060173_ifu
  import ysyx_25060173_ifu_pkg::*;
#(
  parameter int unsigned XLEN     = IFU_XLEN,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                clk,
  input logic                reset,
  ysyx_25060173_ifu_if.master bus
);

  ifu_state_e      state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            fault_q;
  logic            req_valid_q;
  logic            resp_ready_q;
  logic            inst_valid_q;

  logic            pc_misaligned_c;
  logic            next_misaligned_c;

`ifdef YSYX_25060173_IFU_MISALIGN_CHECK_EN
  // Misalignment of the held PC (reset entry) and of the PC being retired to.
  assign pc_misaligned_c   = is_misaligned(pc_q[1:0]);
  assign next_misaligned_c = is_misaligned(bus.next_pc[1:0]);
  assign bus.mem_req_addr  = pc_q;
`else
  // Without the check, misaligned PCs fetch from the enclosing word.
  assign pc_misaligned_c   = 1'b0;
  assign next_misaligned_c = 1'b0;
  assign bus.mem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
`endif

  // Fetch FSM with its PC, instruction and fault registers; handshake outputs are flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= XLEN'(RESET_PC);
      inst_q       <= '0;
      fault_q      <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pc_misaligned_c) begin
            state_q      <= ST_HOLD;
            inst_q       <= NOP_INST;
            fault_q      <= 1'b1;
            inst_valid_q <= 1'b1;
          end else begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            state_q      <= ST_WAIT;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.mem_resp_valid) begin
            state_q      <= ST_HOLD;
            inst_q       <= bus.mem_resp_err ? NOP_INST : 32'(bus.mem_resp_data);
            fault_q      <= bus.mem_resp_err;
            resp_ready_q <= 1'b0;
            inst_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.inst_ready) begin
            pc_q <= bus.next_pc;
            if (next_misaligned_c) begin
              inst_q       <= NOP_INST;
              fault_q      <= 1'b1;
              inst_valid_q <= 1'b1;
            end else begin
              state_q      <= ST_REQ;
              fault_q      <= 1'b0;
              inst_valid_q <= 1'b0;
              req_valid_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Remaining outputs come straight from the architectural registers.
  assign bus.mem_req_valid  = req_valid_q;
  assign bus.mem_resp_ready = resp_ready_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = pc_q;
  assign bus.inst_fault     = fault_q;

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Self-checking bench for ysyx_25060173_ifu: the bench plays memory and core,
// and a small PC/instruction model predicts every fetch.
module tb_ysyx_25060173_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_pc;

  ysyx_25060173_ifu_if #(.XLEN(32)) ifc ();

  ysyx_25060173_ifu #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        timeout;
    logic [31:0] addr;
    logic        req_ok;
    logic        wait_ok;
    int          lat;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic        hold_ok;
    logic        post_req;
    logic        post_valid;
    logic        post_fault;
  } fetch_obs_t;

  // Address the memory should see for a given architectural PC.
  function automatic logic [31:0] exp_addr(input logic [31:0] pc);
`ifdef YSYX_25060173_IFU_MISALIGN_CHECK_EN
    return pc;
`else
    return pc & 32'hFFFF_FFFC;
`endif
  endfunction

  // Plays memory and core for one full fetch and records what was observed.
  task automatic fetch(input int rq_w, input int rs_w, input int hd_w, input logic err,
                       input logic [31:0] data, input logic [31:0] npc, output fetch_obs_t o);
    int n;
    o = '{timeout: 1'b0, addr: '0, req_ok: 1'b1, wait_ok: 1'b1, lat: 0, inst: '0, pc: '0,
          fault: 1'b0, hold_ok: 1'b1, post_req: 1'b0, post_valid: 1'b0, post_fault: 1'b0};
    n = 0;
    while (ifc.mem_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (ifc.mem_req_valid !== 1'b1) begin o.timeout = 1'b1; return; end
    o.addr = ifc.mem_req_addr;
    for (int i = 0; i < rq_w; i++) begin
      ifc.mem_resp_valid = 1'($urandom);
      ifc.inst_ready     = 1'($urandom);
      @(negedge clk);
      if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== o.addr ||
          ifc.mem_resp_ready !== 1'b0 || ifc.inst_valid !== 1'b0) o.req_ok = 1'b0;
    end
    ifc.mem_resp_valid = 1'b0;
    ifc.mem_req_ready  = 1'b1;
    @(negedge clk);
    ifc.mem_req_ready = 1'b0;
    o.lat = 1;
    if (ifc.mem_req_valid !== 1'b0 || ifc.mem_resp_ready !== 1'b1) o.wait_ok = 1'b0;
    for (int i = 0; i < rs_w; i++) begin
      ifc.inst_ready = 1'($urandom);
      @(negedge clk);
      o.lat++;
      if (ifc.inst_valid !== 1'b0 || ifc.mem_req_valid !== 1'b0 || ifc.mem_resp_ready !== 1'b1)
        o.wait_ok = 1'b0;
    end
    ifc.inst_ready     = 1'b0;
    ifc.mem_resp_valid = 1'b1;
    ifc.mem_resp_data  = data;
    ifc.mem_resp_err   = err;
    @(negedge clk);
    o.lat++;
    ifc.mem_resp_valid = 1'b0;
    ifc.mem_resp_err   = 1'b0;
    ifc.mem_resp_data  = $urandom;
    n = 0;
    while (ifc.inst_valid !== 1'b1 && n < 4) begin @(negedge clk); o.lat++; n++; end
    if (ifc.inst_valid !== 1'b1) begin o.timeout = 1'b1; return; end
    o.inst  = ifc.inst;
    o.pc    = ifc.inst_pc;
    o.fault = ifc.inst_fault;
    for (int i = 0; i < hd_w; i++) begin
      ifc.next_pc        = $urandom;
      ifc.mem_resp_valid = 1'($urandom);
      @(negedge clk);
      if (ifc.inst_valid !== 1'b1 || ifc.inst !== o.inst || ifc.inst_pc !== o.pc ||
          ifc.inst_fault !== o.fault || ifc.mem_req_valid !== 1'b0 ||
          ifc.mem_resp_ready !== 1'b0) o.hold_ok = 1'b0;
    end
    ifc.mem_resp_valid = 1'b0;
    ifc.inst_ready     = 1'b1;
    ifc.next_pc        = npc;
    @(negedge clk);
    ifc.inst_ready   = 1'b0;
    ifc.next_pc      = $urandom;
    o.post_req   = ifc.mem_req_valid;
    o.post_valid = ifc.inst_valid;
    o.post_fault = ifc.inst_fault;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ifc.mem_req_valid, ifc.mem_resp_ready, ifc.inst_valid, ifc.inst_fault} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_handshake got=%b exp=0000",
               {ifc.mem_req_valid, ifc.mem_resp_ready, ifc.inst_valid, ifc.inst_fault});
    end
    n_tests++;
    if (ifc.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", ifc.inst); end
    n_tests++;
    if (ifc.inst_pc !== RST_PC || ifc.mem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_pc got pc=%h addr=%h exp=%h", ifc.inst_pc, ifc.mem_req_addr, RST_PC);
    end
    reset = 1'b1;
    m_pc = RST_PC;
  endtask

  task automatic test_first_fetch();
    fetch_obs_t o;
    fetch(0, 0, 0, 1'b0, 32'h0010_0093, 32'h8000_0004, o);
    n_tests++;
    if (o.timeout) begin n_fail++; $display("FAIL first_timeout got=1 exp=0"); return; end
    n_tests++;
    if (o.addr !== 32'h8000_0000) begin n_fail++; $display("FAIL first_addr got=%h exp=80000000", o.addr); end
    n_tests++;
    if (o.lat !== 2) begin n_fail++; $display("FAIL first_latency got=%0d exp=2", o.lat); end
    n_tests++;
    if (o.inst !== 32'h0010_0093 || o.pc !== 32'h8000_0000 || o.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL first_inst got=%h/%h/%b exp=00100093/80000000/0", o.inst, o.pc, o.fault);
    end
    n_tests++;
    if (o.post_req !== 1'b1 || o.post_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_retire_to_req got req=%b valid=%b exp req=1 valid=0", o.post_req, o.post_valid);
    end
    m_pc = 32'h8000_0004;
  endtask

  task automatic test_sequence();
    fetch_obs_t o;
    logic [31:0] npcs [2];
    npcs[0] = 32'h8000_0100;
    npcs[1] = 32'h8000_0104;
    for (int k = 0; k < 2; k++) begin
      fetch(0, 0, 0, 1'b0, 32'h0000_0517 + k, npcs[k], o);
      n_tests++;
      if (o.timeout || o.addr !== exp_addr(m_pc) || o.pc !== m_pc || o.inst !== 32'h0000_0517 + k) begin
        n_fail++;
        $display("FAIL seq_fetch%0d got addr=%h pc=%h inst=%h to=%b exp addr=%h pc=%h inst=%h",
                 k, o.addr, o.pc, o.inst, o.timeout, exp_addr(m_pc), m_pc, 32'h0000_0517 + k);
      end
      m_pc = npcs[k];
    end
  endtask

  task automatic test_stalls();
    fetch_obs_t o;
    fetch(3, 4, 0, 1'b0, 32'h1234_5678, m_pc + 32'd4, o);
    n_tests++;
    if (o.timeout || !o.req_ok || o.addr !== exp_addr(m_pc)) begin
      n_fail++;
      $display("FAIL stall_req got ok=%b addr=%h to=%b exp ok=1 addr=%h", o.req_ok, o.addr, o.timeout, exp_addr(m_pc));
    end
    n_tests++;
    if (!o.wait_ok || o.lat !== 6) begin
      n_fail++;
      $display("FAIL stall_resp got wait_ok=%b lat=%0d exp wait_ok=1 lat=6", o.wait_ok, o.lat);
    end
    n_tests++;
    if (o.inst !== 32'h1234_5678 || o.pc !== m_pc) begin
      n_fail++;
      $display("FAIL stall_inst got=%h/%h exp=12345678/%h", o.inst, o.pc, m_pc);
    end
    m_pc = m_pc + 32'd4;
  endtask

  task automatic test_hold();
    fetch_obs_t o;
    fetch(0, 0, 5, 1'b0, 32'hCAFE_0013, 32'h8000_0200, o);
    n_tests++;
    if (o.timeout || !o.hold_ok || o.inst !== 32'hCAFE_0013 || o.pc !== m_pc) begin
      n_fail++;
      $display("FAIL hold_stable got ok=%b inst=%h pc=%h exp ok=1 inst=cafe0013 pc=%h", o.hold_ok, o.inst, o.pc, m_pc);
    end
    m_pc = 32'h8000_0200;
  endtask

  task automatic test_error();
    fetch_obs_t o;
    fetch(1, 1, 1, 1'b1, 32'hDEAD_BEEF, 32'h8000_0300, o);
    n_tests++;
    if (o.timeout || o.inst !== NOP || o.fault !== 1'b1) begin
      n_fail++;
      $display("FAIL err_inst got inst=%h fault=%b exp inst=00000013 fault=1", o.inst, o.fault);
    end
    n_tests++;
    if (o.post_fault !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", o.post_fault); end
    m_pc = 32'h8000_0300;
    fetch(0, 0, 0, 1'b0, 32'h0000_0093, 32'h8000_0304, o);
    n_tests++;
    if (o.timeout || o.fault !== 1'b0 || o.inst !== 32'h0000_0093) begin
      n_fail++;
      $display("FAIL err_next got inst=%h fault=%b exp inst=00000093 fault=0", o.inst, o.fault);
    end
    m_pc = 32'h8000_0304;
  endtask

  task automatic test_random();
    fetch_obs_t o;
    logic        err;
    logic [31:0] data, npc;
    int          rq, rs, hd;
    for (int k = 0; k < 24; k++) begin
      rq = $urandom_range(0, 3); rs = $urandom_range(0, 3); hd = $urandom_range(0, 3);
      err = ($urandom_range(0, 3) == 0);
      data = $urandom;
      npc = $urandom;
`ifdef YSYX_25060173_IFU_MISALIGN_CHECK_EN
      npc[1:0] = 2'b00;
`endif
      fetch(rq, rs, hd, err, data, npc, o);
      n_tests++;
      if (o.timeout || o.addr !== exp_addr(m_pc) || !o.req_ok || !o.wait_ok || o.lat !== 2 + rs) begin
        n_fail++;
        $display("FAIL rnd%0d_req got addr=%h ok=%b/%b lat=%0d to=%b exp addr=%h lat=%0d",
                 k, o.addr, o.req_ok, o.wait_ok, o.lat, o.timeout, exp_addr(m_pc), 2 + rs);
      end
      n_tests++;
      if (o.inst !== (err ? NOP : data) || o.pc !== m_pc || o.fault !== err || !o.hold_ok) begin
        n_fail++;
        $display("FAIL rnd%0d_inst got %h/%h/%b hold=%b exp %h/%h/%b",
                 k, o.inst, o.pc, o.fault, o.hold_ok, err ? NOP : data, m_pc, err);
      end
      n_tests++;
      if (o.post_req !== 1'b1 || o.post_valid !== 1'b0 || o.post_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_retire got req=%b valid=%b fault=%b exp 1/0/0", k, o.post_req, o.post_valid, o.post_fault);
      end
      m_pc = npc;
    end
  endtask

  task automatic test_misalign();
    fetch_obs_t o;
    fetch(0, 0, 0, 1'b0, 32'h0000_0113, 32'h8000_0002, o);
    m_pc = 32'h8000_0002;
`ifdef YSYX_25060173_IFU_MISALIGN_CHECK_EN
    n_tests++;
    if (o.timeout || o.post_req !== 1'b0 || o.post_valid !== 1'b1 || o.post_fault !== 1'b1 ||
        ifc.inst !== NOP || ifc.inst_pc !== m_pc) begin
      n_fail++;
      $display("FAIL misalign_bypass got req=%b valid=%b fault=%b inst=%h pc=%h exp 0/1/1 %h %h",
               o.post_req, o.post_valid, o.post_fault, ifc.inst, ifc.inst_pc, NOP, m_pc);
    end
    ifc.inst_ready = 1'b1;
    ifc.next_pc    = RST_PC;
    @(negedge clk);
    ifc.inst_ready = 1'b0;
    m_pc = RST_PC;
    n_tests++;
    if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== RST_PC || ifc.inst_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_resume got req=%b addr=%h fault=%b exp 1 %h 0",
               ifc.mem_req_valid, ifc.mem_req_addr, ifc.inst_fault, RST_PC);
    end
`else
    fetch(0, 0, 0, 1'b0, 32'h0000_0213, 32'h8000_0010, o);
    n_tests++;
    if (o.timeout || o.addr !== 32'h8000_0000 || o.pc !== 32'h8000_0002 || o.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_drop got addr=%h pc=%h fault=%b to=%b exp 80000000 80000002 0",
               o.addr, o.pc, o.fault, o.timeout);
    end
    m_pc = 32'h8000_0010;
`endif
  endtask

  task automatic test_reset_in_wait();
    fetch_obs_t o;
    int n = 0;
    while (ifc.mem_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    ifc.mem_req_ready = 1'b1;
    @(negedge clk);
    ifc.mem_req_ready = 1'b0;
    n_tests++;
    if (ifc.mem_resp_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_enter got=%b exp=1", ifc.mem_resp_ready); end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({ifc.mem_req_valid, ifc.mem_resp_ready, ifc.inst_valid, ifc.inst_fault} !== 4'b0000 ||
        ifc.inst !== 32'h0 || ifc.inst_pc !== RST_PC || ifc.mem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rstwait_outputs got hs=%b inst=%h pc=%h addr=%h exp 0000 0 %h %h",
               {ifc.mem_req_valid, ifc.mem_resp_ready, ifc.inst_valid, ifc.inst_fault},
               ifc.inst, ifc.inst_pc, ifc.mem_req_addr, RST_PC, RST_PC);
    end
    @(negedge clk);
    reset = 1'b1;
    m_pc = RST_PC;
    fetch(0, 0, 0, 1'b0, 32'h0010_0093, 32'h8000_0004, o);
    n_tests++;
    if (o.timeout || o.addr !== RST_PC || o.pc !== RST_PC || o.inst !== 32'h0010_0093) begin
      n_fail++;
      $display("FAIL rstwait_refetch got addr=%h pc=%h inst=%h exp %h %h 00100093", o.addr, o.pc, o.inst, RST_PC, RST_PC);
    end
    m_pc = 32'h8000_0004;
  endtask

  initial begin
    ifc.mem_req_ready  = 1'b0;
    ifc.mem_resp_valid = 1'b0;
    ifc.mem_resp_data  = '0;
    ifc.mem_resp_err   = 1'b0;
    ifc.inst_ready     = 1'b0;
    ifc.next_pc        = '0;
    m_pc               = RST_PC;
    test_reset();
    test_first_fetch();
    test_sequence();
    test_stalls();
    test_hold();
    test_error();
    test_random();
    test_misalign();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_25060173_ifu.md
Name: ysyx_25060173_ifu

Overview:
- Instruction fetch unit directly upstream of the single-cycle core.
- Owns the architectural fetch PC and issues one 32-bit instruction read at a time over a valid/ready memory interface.
- Presents the returned instruction to the core with a valid/ready handshake.
- Loads the core-computed next PC when the core retires the instruction.

Parameters:
- RESET_PC, 32'h80000000, PC loaded on reset.
- XLEN, 32, address/data width; only 32 supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  XLEN  fetch address.
- mem_resp_valid  input  1  read data valid.
- mem_resp_ready  output  1  IFU accepts response.
- mem_resp_data  input  XLEN  instruction word.
- mem_resp_err  input  1  access error with response.
- inst_valid  output  1  inst/inst_pc valid toward core.
- inst_ready  input  1  core retires current instruction.
- inst  output  32  instruction word to core.
- inst_pc  output  XLEN  PC of inst.
- inst_fault  output  1  current inst is a fetch fault.
- next_pc  input  XLEN  core's computed next PC (jal/jalr/pc+4).

Behaviour:
- Reset (reset=0, async): state=IDLE, pc_reg=RESET_PC, inst_reg=0, fault_reg=0.
  - All outputs 0, except inst_pc=RESET_PC and mem_req_addr=RESET_PC.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - All handshake outputs 0.
  - Unconditional transition to REQ on the first clk edge after reset deasserts.
- REQ:
  - mem_req_valid=1, mem_req_addr=pc_reg.
  - On mem_req_ready=1 → WAIT. Otherwise stay; valid and addr held stable.
- WAIT:
  - mem_resp_ready=1.
  - On mem_resp_valid=1: inst_reg←mem_resp_data, fault_reg←mem_resp_err, → HOLD.
  - If mem_resp_err=1, inst_reg←32'h00000013 (NOP) instead of the data.
- HOLD:
  - inst_valid=1, inst=inst_reg, inst_pc=pc_reg, inst_fault=fault_reg.
  - On inst_ready=1: pc_reg←next_pc, fault_reg←0, → REQ.
  - Otherwise hold all outputs stable.
- Outstanding requests: exactly one. No new request until the previous instruction retires.
- mem_resp_valid outside WAIT: ignored, not consumed, mem_resp_ready=0.
- inst_ready outside HOLD: ignored. next_pc is sampled only on the inst_valid&&inst_ready cycle.
- Latency (zero-wait memory):
  - Request accepted cycle N; response cycle N+1; inst_valid asserted cycle N+2.
  - Retire at N+2 → next request at N+3. Best-case throughput is 1 instruction per 3 cycles.
- Memory side is reset by the same reset. An in-flight transaction is abandoned on reset; there is no drain logic.
- All outputs are driven from registers (state, pc_reg, inst_reg, fault_reg). No combinational path from inputs to outputs.

Optional Feature:
- Macro: YSYX_25060173_IFU_MISALIGN_CHECK_EN.
- Defined:
  - On retire, if next_pc[1:0]!=0: pc_reg←next_pc, no memory request issued, go directly REQ-bypass → HOLD.
  - HOLD then presents inst=NOP and inst_fault=1.
  - The RESET_PC check is the same.
- Undefined: mem_req_addr={pc_reg[XLEN-1:2],2'b00}; low bits are silently dropped and no fault is raised.

Decomposition:
- Package ysyx_25060173_ifu_pkg:
  - state enum (IDLE/REQ/WAIT/HOLD, 2-bit);
  - NOP_INST=32'h00000013;
  - DEFAULT_RESET_PC.
- No sub-module. The FSM and the three registers are inline in one module.

Test Plan:
- Reset release, memory ready=1, 1-cycle response 0x00100093 → mem_req_addr=0x80000000 on the first REQ cycle; inst_valid 2 cycles after acceptance with inst=0x00100093, inst_pc=0x80000000.
- Core retires with next_pc=0x80000004, then 0x80000100 (jal) → next requests at 0x80000004 then 0x80000100; each fetch presents the matching inst_pc.
- mem_req_ready low 3 cycles, mem_resp_valid delayed 4 cycles → valid and addr stable throughout REQ; no duplicate request; inst_valid only after the response.
- inst_ready held low 5 cycles in HOLD → inst, inst_pc and inst_valid stable; mem_req_valid stays 0.
- mem_resp_err=1 with data 0xDEADBEEF → inst=0x00000013, inst_fault=1; inst_fault clears after retire.
- reset asserted during WAIT → outputs return to reset values immediately; the next fetch is at 0x80000000. With the macro defined, next_pc=0x80000002 → no request, inst_fault=1, inst_pc=0x80000002.
